// File: rtl/jk_pkg.sv
// Shared types and constants for the JK target driver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package jk_pkg;

    // Transfer sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2
    } jk_state_t;

    // Two-bit excitation codes, ordered {J, K}
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    // Retry counter width; stays at least one bit wide when no retries are allowed
    function automatic int cnt_w(input int max_retry);
        return (max_retry < 1) ? 1 : $clog2(max_retry + 1);
    endfunction

endpackage

// File: rtl/jk_excite_enc.sv
// Single-bit JK excitation encoder: J/K that move q to q_next in one clock.
// Latency: purely combinational.
// Backpressure: none; dc selects the value used for the don't-care input.
module jk_excite_enc
    import jk_pkg::*;
(
    input  logic q,
    input  logic q_next,
    input  logic dc,
    output logic j,
    output logic k
);

    logic [1:0] code;

    // Excitation table; the don't-care half of each code is taken from dc
    always_comb begin
        code = JK_HOLD;
        case ({q, q_next})
            2'b00: code = dc ? JK_RST : JK_HOLD;  // J=0, K=dc
            2'b01: code = dc ? JK_TGL : JK_SET;   // J=1, K=dc
            2'b10: code = dc ? JK_TGL : JK_RST;   // J=dc, K=1
            2'b11: code = dc ? JK_SET : JK_HOLD;  // J=dc, K=0
            default: code = JK_HOLD;
        endcase
    end

    assign j = code[1];
    assign k = code[0];

endmodule

// File: rtl/jk_target_driver.sv
// Drives a JK flip-flop bank to a requested word, verifying and retrying on mismatch.
// Latency: accept at edge T, DRIVE T+1, CHECK T+2, done/err T+3; +2 cycles per retry.
// Backpressure: tgt_ready is high only in IDLE; targets offered while busy wait.
module jk_target_driver
    import jk_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_RETRY = 3,
    parameter int DC_POLICY = 0
)
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        tgt_valid,
    input  logic [WIDTH-1:0]            tgt_data,
    output logic                        tgt_ready,
    input  logic [WIDTH-1:0]            q_fb,
    output logic [WIDTH-1:0]            j_out,
    output logic [WIDTH-1:0]            k_out,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic [cnt_w(MAX_RETRY)-1:0] retry_cnt
);

    localparam int             RCW         = cnt_w(MAX_RETRY);
    localparam logic [RCW-1:0] RETRY_LIMIT = RCW'(MAX_RETRY);
    localparam logic           DC_BIT      = (DC_POLICY != 0);

    jk_state_t        state;
    logic [WIDTH-1:0] tgt_q;
    logic [WIDTH-1:0] j_exc;
    logic [WIDTH-1:0] k_exc;

    // Per-bit excitation from live feedback, so every retry starts from the current Q
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_excite_enc u_enc (
            .q      (q_fb[i]),
            .q_next (tgt_q[i]),
            .dc     (DC_BIT),
            .j      (j_exc[i]),
            .k      (k_exc[i])
        );
    end

    // J/K are gated by the state register, so an async reset forces hold immediately
    assign j_out = (state == ST_DRIVE) ? j_exc : '0;
    assign k_out = (state == ST_DRIVE) ? k_exc : '0;

    // Transfer sequencer with registered handshake and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            tgt_q     <= '0;
            retry_cnt <= '0;
            tgt_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tgt_valid) begin
                        tgt_q     <= tgt_data;
                        retry_cnt <= '0;
                        tgt_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (q_fb == tgt_q) begin
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        tgt_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end else if (retry_cnt < RETRY_LIMIT) begin
                        retry_cnt <= retry_cnt + 1'b1;
                        state     <= ST_DRIVE;
                    end else begin
                        err       <= 1'b1;
                        busy      <= 1'b0;
                        tgt_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    busy      <= 1'b0;
                    tgt_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_target_driver.sv
// Testbench: two drivers (DC_POLICY 0 and 1) each closing the loop through a model JK bank.
// Latency: checks accept/DRIVE/CHECK/done timing and retry latency.
// Backpressure: checks tgt_ready in every phase and back-to-back acceptance.
module tb_jk_target_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tgt_data;
    logic       valid0, valid1;
    logic       ready0, ready1;
    logic [7:0] fb0, fb1, j0, k0, j1, k1, bank0, bank1;
    logic       busy0, busy1, done0, done1, err0, err1;
    logic [1:0] rc0, rc1;
    logic       stuck0;
    logic       release3;

    int n_chk  = 0;
    int n_fail = 0;
    int overlap = 0;
    int pulses0 = 0;

    always #5 clk = ~clk;

    // Bit 0 of the first bank's feedback can be held at 0 to model a stuck output
    assign fb0 = bank0 & ~{7'b0, stuck0};
    assign fb1 = bank1;

    // Model JK flip-flop banks: Q+ = J&~Q | ~K&Q
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank0 <= '0;
            bank1 <= '0;
        end else begin
            bank0 <= (j0 & ~bank0) | (~k0 & bank0);
            bank1 <= (j1 & ~bank1) | (~k1 & bank1);
        end
    end

    // Pulse bookkeeping away from the active edge
    always @(negedge clk) begin
        if ((done0 && err0) || (done1 && err1)) overlap++;
        if (done0 || err0) pulses0++;
    end

    jk_target_driver #(.WIDTH(8), .MAX_RETRY(3), .DC_POLICY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .tgt_valid(valid0), .tgt_data(tgt_data),
        .tgt_ready(ready0), .q_fb(fb0), .j_out(j0), .k_out(k0),
        .busy(busy0), .done(done0), .err(err0), .retry_cnt(rc0)
    );

    jk_target_driver #(.WIDTH(8), .MAX_RETRY(3), .DC_POLICY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .tgt_valid(valid1), .tgt_data(tgt_data),
        .tgt_ready(ready1), .q_fb(fb1), .j_out(j1), .k_out(k1),
        .busy(busy1), .done(done1), .err(err1), .retry_cnt(rc1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one target to dut0 and wait (bounded) for done or err
    task automatic run0(input logic [7:0] tgt, output int lat, output logic got_done,
                        output logic got_err);
        tgt_data = tgt;
        valid0   = 1'b1;
        step();
        valid0 = 1'b0;
        lat = 1;
        while (!done0 && !err0 && lat < 30) begin
            step();
            lat++;
            if (lat == 3 && release3) stuck0 = 1'b0;
        end
        got_done = done0;
        got_err  = err0;
    endtask

    typedef struct {
        logic [7:0] tgt;
        logic [7:0] j0;
        logic [7:0] k0;
        logic [7:0] j1;
        logic [7:0] k1;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   lat, drives, errs, dones, err_at, snap;
        logic gd, ge;

        // Expected J/K derived bit-by-bit from the excitation table
        vecs[0] = '{8'hA5, 8'hA5, 8'h00, 8'hA5, 8'hFF};  // 00 -> A5
        vecs[1] = '{8'h3C, 8'h18, 8'h81, 8'hBD, 8'hDB};  // A5 -> 3C
        vecs[2] = '{8'h3C, 8'h00, 8'h00, 8'h3C, 8'hC3};  // 3C -> 3C
        vecs[3] = '{8'h00, 8'h00, 8'h3C, 8'h3C, 8'hFF};  // 3C -> 00
        vecs[4] = '{8'hFF, 8'hFF, 8'h00, 8'hFF, 8'hFF};  // 00 -> FF

        valid0 = 1'b0; valid1 = 1'b0; tgt_data = '0; stuck0 = 1'b0; release3 = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_j0", j0, 0);
        chk("reset_k0", k0, 0);
        chk("reset_j1", j1, 0);
        chk("reset_busy", busy0, 0);
        chk("reset_done", done0, 0);
        chk("reset_err", err0, 0);
        chk("reset_retry", rc0, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        chk("ready_after_reset0", ready0, 1);
        chk("ready_after_reset1", ready1, 1);

        // Table: same target to both policies, check drive codes and timing
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("v%0d_ready_idle", i), ready0, 1);
            tgt_data = vecs[i].tgt;
            valid0 = 1'b1; valid1 = 1'b1;
            step();
            valid0 = 1'b0; valid1 = 1'b0;
            chk($sformatf("v%0d_j_dc0", i), j0, vecs[i].j0);
            chk($sformatf("v%0d_k_dc0", i), k0, vecs[i].k0);
            chk($sformatf("v%0d_j_dc1", i), j1, vecs[i].j1);
            chk($sformatf("v%0d_k_dc1", i), k1, vecs[i].k1);
            chk($sformatf("v%0d_busy_drive", i), busy0, 1);
            chk($sformatf("v%0d_ready_drive", i), ready0, 0);
            step();
            chk($sformatf("v%0d_jk_check", i), {j0, k0, j1, k1}, 0);
            chk($sformatf("v%0d_ready_check", i), ready1, 0);
            chk($sformatf("v%0d_done_early", i), done0, 0);
            step();
            chk($sformatf("v%0d_done0", i), done0, 1);
            chk($sformatf("v%0d_done1", i), done1, 1);
            chk($sformatf("v%0d_err0", i), err0, 0);
            chk($sformatf("v%0d_busy_end", i), busy0, 0);
            chk($sformatf("v%0d_q0", i), bank0, vecs[i].tgt);
            chk($sformatf("v%0d_q1", i), bank1, vecs[i].tgt);
            chk($sformatf("v%0d_retry", i), rc0, 0);
            step();
            chk($sformatf("v%0d_done_pulse", i), done0, 0);
        end

        // Bit 0 permanently stuck: four drives then a single err pulse
        stuck0 = 1'b1;
        tgt_data = 8'h01;
        valid0 = 1'b1;
        step();
        valid0 = 1'b0;
        drives = 0; errs = 0; dones = 0; err_at = 0;
        for (int c = 1; c <= 14; c++) begin
            if (busy0 && j0[0]) drives++;
            if (err0) begin errs++; err_at = c; end
            if (done0) dones++;
            step();
        end
        chk("stuck_drives", drives, 4);
        chk("stuck_err_pulses", errs, 1);
        chk("stuck_err_latency", err_at, 9);
        chk("stuck_no_done", dones, 0);
        chk("stuck_retry_cnt", rc0, 3);
        chk("stuck_ready", ready0, 1);
        stuck0 = 1'b0;

        run0(8'h00, lat, gd, ge);
        chk("clear_done", gd, 1);
        chk("clear_latency", lat, 3);
        step();

        // Stuck only for the first check: one retry then done
        stuck0 = 1'b1;
        release3 = 1'b1;
        run0(8'h01, lat, gd, ge);
        release3 = 1'b0;
        chk("transient_done", gd, 1);
        chk("transient_err", ge, 0);
        chk("transient_latency", lat, 5);
        chk("transient_retry", rc0, 1);
        chk("transient_q", bank0, 8'h01);
        step();
        chk("retry_hold", rc0, 1);

        // Back-to-back with valid held; mid-transfer data change must be ignored
        tgt_data = 8'h11;
        valid0 = 1'b1;
        step();
        tgt_data = 8'h22;
        chk("b2b_ready_drive", ready0, 0);
        chk("b2b_j_first", j0, 8'h10);
        step();
        chk("b2b_ready_check", ready0, 0);
        step();
        chk("b2b_done_first", done0, 1);
        chk("b2b_ready_done", ready0, 1);
        chk("b2b_q_first", bank0, 8'h11);
        step();
        valid0 = 1'b0;
        chk("b2b_busy_second", busy0, 1);
        chk("b2b_j_second", j0, 8'h22);
        chk("b2b_k_second", k0, 8'h11);
        step();
        step();
        chk("b2b_done_second", done0, 1);
        chk("b2b_q_second", bank0, 8'h22);
        step();

        // Reset during DRIVE: J/K drop without a clock edge, no completion pulse
        tgt_data = 8'h55;
        valid0 = 1'b1;
        step();
        valid0 = 1'b0;
        chk("rst_j_before", j0, 8'h55);
        snap = pulses0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_j", j0, 0);
        chk("rst_async_k", k0, 0);
        chk("rst_async_busy", busy0, 0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("rst_ready_after", ready0, 1);
        chk("rst_busy_after", busy0, 0);
        repeat (3) step();
        chk("rst_no_pulse", pulses0 - snap, 0);
        chk("rst_retry_cleared", rc0, 0);

        chk("done_err_exclusive", overlap, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
